console_uart_tx: RTL and testbench

//  Downstream consumer of the data-memory request bus. Snoops core data writes to the

---
 rtl/console_pkg.sv | 21 ++
 rtl/console_uart_tx_if.sv | 9 +
 rtl/console_uart_tx_byte_fifo.sv | 43 ++++
 rtl/console_uart_tx.sv | 136 +++++++++++++
 tb/tb_console_uart_tx.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/console_pkg.sv
// Shared types and addresses for the console UART: request bus payload, MMIO map, TX FSM states.
package console_pkg;

  localparam logic [31:0] CONSOLE_ADDR = 32'h0002_FFF8;
  localparam logic [31:0] HALT_ADDR    = 32'h0002_FFFC;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_write;
  } memory_io_req;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/console_uart_tx_if.sv
// Data-memory request bus as seen by a snooping consumer.
interface console_uart_tx_if;
  import console_pkg::*;

  memory_io_req pkt;

  modport master (output pkt);
  modport slave  (input  pkt);
endinterface

// File: rtl/console_uart_tx_byte_fifo.sv
// Byte FIFO, power-of-two depth, no bypass; pointers carry one extra wrap bit.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/console_uart_tx.sv
// Snoops console MMIO writes into a FIFO and serializes them as 8N1 UART frames.
module console_uart_tx
  import console_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = console_pkg::CONSOLE_ADDR,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  console_uart_tx_if.slave    req,
  output logic                tx,
  output logic                idle,
  output logic                overflow,
  output logic [15:0]         drop_count
);
  localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        tx_nxt;

  logic        capture, push, pop, drop;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        unused_bits;

  assign unused_bits = ^req.pkt.data[31:8];

  assign capture = req.pkt.valid && (req.pkt.addr == CONSOLE_ADDR) && (req.pkt.do_write == 4'b1111);
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;
  assign idle    = (state == IDLE) && fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req.pkt.data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  // Next-state, baud counter, shifter and FIFO pop; tx decoded from the next state.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    tx_nxt      = 1'b1;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          cnt_nxt   = BAUD_LOAD;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == 16'd0) begin
          cnt_nxt     = BAUD_LOAD;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          shift_nxt = {1'b0, shift[7:1]};
          cnt_nxt   = BAUD_LOAD;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == 16'd0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            cnt_nxt   = BAUD_LOAD;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_console_uart_tx;
  import console_pkg::*;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx;
  logic        idle;
  logic        overflow;
  logic [15:0] drop_count;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  console_uart_tx_if bus ();

  console_uart_tx #(
    .CONSOLE_ADDR (CONSOLE_ADDR),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus),
    .tx         (tx),
    .idle       (idle),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.pkt.valid    = v;
    bus.pkt.addr     = a;
    bus.pkt.data     = d;
    bus.pkt.do_write = be;
  endtask

  // Waits for a start bit, then samples mid-bit; s = cycle of first low sample.
  task automatic frame_check(input logic [7:0] b, input string tag, output int s);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (tx !== 1'b0 && n < 300);
    chk({tag, " start_seen"}, 32'(tx), 32'd0);
    s = cyc;
    step(2);
    chk({tag, " start_mid"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(4);
      chk($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(b[i]));
    end
    step(4);
    chk({tag, " stop"}, 32'(tx), 32'd1);
  endtask

  initial begin
    int e, s1, s2, lows;
    reset = 1'b1;
    bus.pkt = '0;

    // 1: reset state
    step(3);
    @(negedge clk) reset = 1'b0;
    step(20);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst idle", 32'(idle), 32'd1);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);

    // 2: single 'A' frame with exact latency
    put(1'b1, CONSOLE_ADDR, 32'h0000_0041, 4'hF);
    step(1);
    e = cyc;
    bus.pkt.valid = 1'b0;
    chk("A idle_after_push", 32'(idle), 32'd0);
    frame_check(8'h41, "A", s1);
    chk("A latency", 32'(s1 - e), 32'd1);
    step(1);
    chk("A idle_E40", 32'(idle), 32'd0);
    step(1);
    chk("A idle_E41", 32'(idle), 32'd1);
    chk("A tx_E41", 32'(tx), 32'd1);

    // 3: ignored accesses
    put(1'b0, CONSOLE_ADDR, 32'h0000_0042, 4'hF);
    put(1'b1, HALT_ADDR,    32'h0000_0043, 4'hF);
    put(1'b1, CONSOLE_ADDR, 32'h0000_0044, 4'b0001);
    put(1'b0, 32'h0, 32'h0, 4'h0);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tx !== 1'b1 || idle !== 1'b1) lows++;
    end
    chk("ignored activity", 32'(lows), 32'd0);
    chk("ignored overflow", 32'(overflow), 32'd0);

    // 4: 20 back-to-back writes overflow the FIFO by three
    fork
      begin
        for (int i = 0; i < 20; i++) put(1'b1, CONSOLE_ADDR, 32'(8'h30 + i), 4'hF);
        put(1'b0, 32'h0, 32'h0, 4'h0);
      end
      begin
        for (int k = 0; k < 17; k++) frame_check(8'(8'h30 + k), $sformatf("burst%0d", k), s1);
      end
    join
    chk("burst overflow", 32'(overflow), 32'd1);
    chk("burst drop_count", 32'(drop_count), 32'd3);
    step(4);
    chk("burst idle", 32'(idle), 32'd1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (tx !== 1'b1) lows++;
    end
    chk("burst no_extra_frames", 32'(lows), 32'd0);

    // 5: two frames with no gap
    fork
      begin
        put(1'b1, CONSOLE_ADDR, 32'h0000_0055, 4'hF);
        put(1'b1, CONSOLE_ADDR, 32'h0000_00AA, 4'hF);
        put(1'b0, 32'h0, 32'h0, 4'h0);
      end
      begin
        frame_check(8'h55, "b2b0", s1);
        frame_check(8'hAA, "b2b1", s2);
      end
    join
    chk("b2b period", 32'(s2 - s1), 32'd40);
    chk("b2b drop_count", 32'(drop_count), 32'd3);

    // 6: reset in the middle of a frame
    step(10);
    put(1'b1, CONSOLE_ADDR, 32'h0000_0000, 4'hF);
    put(1'b1, CONSOLE_ADDR, 32'h0000_0011, 4'hF);
    put(1'b1, CONSOLE_ADDR, 32'h0000_0022, 4'hF);
    put(1'b0, 32'h0, 32'h0, 4'h0);
    step(10);
    chk("midrst tx_low_before", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("midrst tx", 32'(tx), 32'd1);
    chk("midrst idle", 32'(idle), 32'd1);
    chk("midrst overflow", 32'(overflow), 32'd0);
    chk("midrst drop_count", 32'(drop_count), 32'd0);
    step(2);
    @(negedge clk) reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (tx !== 1'b1 || idle !== 1'b1) lows++;
    end
    chk("midrst no_frames", 32'(lows), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
